// File: rtl/xyolo_read_stage.sv
// Read stage of the xyolo pipeline: fetches a bias beat and weight beats into N_VECT banks,
// then streams bank rows to the write stage with accumulate/result qualifiers.
module xyolo_read_stage #(
   parameter int DATAPATH_W = 32,
   parameter int N_VECT     = 4,
   parameter int N_MACS     = 8,
   parameter int DATABUS_W  = 256,
   parameter int IO_ADDR_W  = 32,
   parameter int ADDR_W     = 6
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  run,
   output logic                                  done,
   input  logic [IO_ADDR_W-1:0]                  ext_addr,
   input  logic [ADDR_W+$clog2(N_VECT)-1:0]      n_beats,
   input  logic [15:0]                           iter,
   input  logic [ADDR_W:0]                       per,
   output logic                                  databus_valid,
   input  logic                                  databus_ready,
   output logic [IO_ADDR_W-1:0]                  databus_addr,
   input  logic [DATABUS_W-1:0]                  databus_rdata,
   output logic [N_VECT*DATAPATH_W-1:0]          flow_out_bias,
   output logic [N_VECT*N_MACS*DATAPATH_W-1:0]   flow_out_weight,
   output logic                                  flow_valid,
   output logic                                  ld_acc,
   output logic                                  ld_res
);

   localparam int VW         = $clog2(N_VECT);
   localparam int NB_W       = ADDR_W + VW;
   localparam int BEAT_BYTES = DATABUS_W / 8;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FETCH_B = 2'd1;
   localparam logic [1:0] S_FETCH_W = 2'd2;
   localparam logic [1:0] S_STREAM  = 2'd3;

   logic [1:0]                      r_state;
   logic [IO_ADDR_W-1:0]            r_base;
   logic [NB_W-1:0]                 r_nb;
   logic [15:0]                     r_iter;
   logic [ADDR_W:0]                 r_per;
   logic [NB_W:0]                   r_k;
   logic [NB_W-1:0]                 r_m;
   logic [ADDR_W:0]                 r_j;
   logic [15:0]                     r_it;
   logic                            r_done;
   logic [N_VECT*DATAPATH_W-1:0]    r_bias;
   logic                            r_fv;
   logic                            r_acc;
   logic                            r_res;
   logic [DATABUS_W-1:0]            r_bank [N_VECT][2**ADDR_W];
   logic [DATABUS_W-1:0]            r_rd   [N_VECT];

   logic w_accept;
   logic w_last_beat;
   logic w_empty;
   logic w_issue;
   logic w_j_last;
   logic w_it_last;

   // NOTE: valid is decoded from the async-reset state register, so rst drops it within the same cycle.
   assign databus_valid = (r_state == S_FETCH_B) || (r_state == S_FETCH_W);
   assign databus_addr  = r_base + IO_ADDR_W'(r_k) * IO_ADDR_W'(BEAT_BYTES);
   assign w_accept      = databus_valid && databus_ready;
   assign w_last_beat   = (r_m == r_nb - NB_W'(1));
   assign w_empty       = (r_iter == 16'd0) || (r_per == '0);
   assign w_issue       = (r_state == S_STREAM) && !w_empty;
   assign w_j_last      = (r_j == r_per - (ADDR_W+1)'(1));
   assign w_it_last     = (r_it == r_iter - 16'd1);

   assign done          = r_done;
   assign flow_out_bias = r_bias;
   assign flow_valid    = r_fv;
   assign ld_acc        = r_acc;
   assign ld_res        = r_res;

   // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_base  <= '0;
         r_nb    <= '0;
         r_iter  <= '0;
         r_per   <= '0;
         r_k     <= '0;
         r_m     <= '0;
         r_j     <= '0;
         r_it    <= '0;
         r_done  <= 1'b1;
         r_bias  <= '0;
         r_fv    <= 1'b0;
         r_acc   <= 1'b0;
         r_res   <= 1'b0;
      end else begin
         r_fv  <= w_issue;
         r_acc <= w_issue && (r_j == '0);
         r_res <= w_issue && w_j_last;
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_base  <= ext_addr;
                  r_nb    <= n_beats;
                  r_iter  <= iter;
                  r_per   <= per;
                  r_k     <= '0;
                  r_m     <= '0;
                  r_j     <= '0;
                  r_it    <= '0;
                  r_done  <= 1'b0;
                  r_state <= S_FETCH_B;
               end else begin
                  // Entering IDLE with the final flow beat in flight: done rises one cycle later.
                  r_done <= 1'b1;
               end
            end
            S_FETCH_B: begin
               if (w_accept) begin
                  r_bias  <= databus_rdata[N_VECT*DATAPATH_W-1:0];
                  r_k     <= r_k + (NB_W+1)'(1);
                  r_state <= (r_nb == '0) ? S_STREAM : S_FETCH_W;
               end
            end
            S_FETCH_W: begin
               if (w_accept) begin
                  r_k <= r_k + (NB_W+1)'(1);
                  r_m <= r_m + NB_W'(1);
                  if (w_last_beat) r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (w_empty) begin
                  r_state <= S_IDLE;
               end else if (w_j_last) begin
                  r_j  <= '0;
                  r_it <= r_it + 16'd1;
                  if (w_it_last) r_state <= S_IDLE;
               end else begin
                  r_j <= r_j + (ADDR_W+1)'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: weight banks are plain RAM with no reset; contents survive rst and earlier jobs.
   always_ff @(posedge clk) begin
      if ((r_state == S_FETCH_W) && w_accept)
         r_bank[r_m[VW-1:0]][r_m[NB_W-1:VW]] <= databus_rdata;
      for (int v = 0; v < N_VECT; v++)
         r_rd[v] <= r_bank[v][r_j[ADDR_W-1:0]];
   end

   for (genvar g = 0; g < N_VECT; g++) begin : g_weight
      assign flow_out_weight[(N_VECT-g)*DATABUS_W-1 -: DATABUS_W] = r_rd[g];
   end

endmodule

// File: doc/xyolo_read_stage.md
XYOLO_READ_STAGE -- requirements
Module: xyolo_read_stage

Interface
REQ-001 The block SHALL have parameter DATAPATH_W, default 32, meaning datapath word width.
REQ-002 The block SHALL have parameter N_VECT, default 4, meaning number of xyolo vectors fed.
REQ-003 The block SHALL have parameter N_MACS, default 8, meaning MACs per vector.
REQ-004 The block SHALL have parameter DATABUS_W, default 256, meaning databus beat width; DATABUS_W SHALL equal N_MACS*DATAPATH_W.
REQ-005 The block SHALL have parameter IO_ADDR_W, default 32, meaning external byte address width.
REQ-006 The block SHALL have parameter ADDR_W, default 6, meaning weight bank address width (depth 2^ADDR_W).
REQ-007 Port clk, input, 1: clock; all state SHALL update on rising edge.
REQ-008 Port rst, input, 1: reset, asynchronous, active-high.
REQ-009 Port run, input, 1: start pulse.
REQ-010 Port done, output, 1: block idle and last job complete.
REQ-011 Port ext_addr, input, IO_ADDR_W: byte address of bias beat.
REQ-012 Port n_beats, input, ADDR_W+log2(N_VECT): weight beats to fetch.
REQ-013 Port iter, input, 16: stream iterations.
REQ-014 Port per, input, ADDR_W+1: read addresses per iteration.
REQ-015 Ports databus_valid (out, 1), databus_ready (in, 1), databus_addr (out, IO_ADDR_W), databus_rdata (in, DATABUS_W): read-only databus.
REQ-016 Port flow_out_bias, output, N_VECT*DATAPATH_W: bias vector, vector 0 in MSBs.
REQ-017 Port flow_out_weight, output, N_VECT*N_MACS*DATAPATH_W: weights, vector 0 in MSBs.
REQ-018 Ports flow_valid, ld_acc, ld_res, output, 1 each: stream qualifiers for the downstream write stage.

Function
REQ-019 FSM states SHALL be IDLE, FETCH_B, FETCH_W, STREAM; run is sampled only in IDLE, ignored otherwise.
REQ-020 Transitions: IDLE-(run)->FETCH_B; FETCH_B-(beat accepted)->FETCH_W, or ->STREAM if n_beats=0; FETCH_W-(n_beats-th beat accepted)->STREAM; STREAM-(last address issued)->IDLE.
REQ-021 A beat SHALL be accepted on a cycle with databus_valid=1 and databus_ready=1; databus_valid SHALL be 1 throughout FETCH_B/FETCH_W and 0 otherwise.
REQ-022 databus_addr SHALL equal ext_addr + (DATABUS_W/8)*k for beat k (k=0 bias, k>=1 weights), held until accepted; ext_addr is latched on run.
REQ-023 Bias beat: low N_VECT*DATAPATH_W bits of databus_rdata SHALL be registered into flow_out_bias on acceptance.
REQ-024 Weight beat m (0-based) SHALL be written to bank m mod N_VECT at address m div N_VECT; unwritten entries keep prior contents.
REQ-025 STREAM SHALL issue read address j=0..per-1, repeated iter times, one per cycle; all banks read at j synchronously.
REQ-026 flow_out_weight, flow_valid, ld_acc, ld_res SHALL appear 1 cycle after address issue; ld_acc=1 with j=0 data, ld_res=1 with j=per-1 data (both when per=1).
REQ-027 iter=0 or per=0 SHALL skip STREAM outputs (flow_valid never asserted) and return to IDLE.
REQ-028 done SHALL be 0 from the cycle after run until the cycle after the last flow_valid (or after the FSM returns to IDLE if STREAM emits nothing), then 1.
REQ-029 Simultaneous run and done=1: run wins; done falls next cycle.

Reset
REQ-030 rst SHALL force IDLE, done=1, databus_valid=0, databus_addr=0, flow_valid=ld_acc=ld_res=0, flow_out_bias=0, all counters 0; flow_out_weight value undefined; bank contents not cleared.
REQ-031 rst mid-fetch SHALL drop databus_valid immediately (asynchronously) with no further beats accepted; mid-stream SHALL drop flow_valid immediately.

Verification
REQ-032 ext_addr=0x1000, n_beats=8, ready always 1 -> addrs 0x1000..0x1100 step 0x20, 9 beats, FETCH ends cycle 10.
REQ-033 ready toggled 1-of-3 cycles -> databus_addr stable while ready=0; bank contents equal beat data (bank m%4, addr m/4).
REQ-034 iter=3, per=2 -> 6 flow_valid cycles, ld_acc on 1st/3rd/5th, ld_res on 2nd/4th/6th, done=1 cycle after 6th.
REQ-035 n_beats=0, per=1, iter=2 -> one bus beat, then 2 flow_valid with ld_acc=ld_res=1 each.
REQ-036 rst asserted on 4th fetch beat -> databus_valid=0 same cycle, done=1; new run restarts at ext_addr.
REQ-037 run pulsed during STREAM -> ignored, output sequence unchanged.
